// File: rtl/multi_sample_iterator.sv
// Walks a triangle's bounding box in raster order, emitting SAMPLES sample
// positions per cycle and holding the triangle and color steady for the pass.
module multi_sample_iterator #(
   parameter int SIGFIG  = 24,
   parameter int RADIX   = 10,
   parameter int VERTS   = 3,
   parameter int AXIS    = 3,
   parameter int COLORS  = 3,
   parameter int SAMPLES = 2
) (
   input  logic                                               clk,
   input  logic                                               rst,
   input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]      tri_R13S,
   input  logic        [COLORS-1:0][SIGFIG-1:0]               color_R13U,
   input  logic signed [1:0][1:0][SIGFIG-1:0]                 box_R13S,
   input  logic        [3:0]                                  subSample_R13U,
   input  logic                                               validTri_R13H,
   output logic                                               halt_R13H,
   output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]      tri_R14S,
   output logic        [COLORS-1:0][SIGFIG-1:0]               color_R14U,
   output logic signed [SAMPLES-1:0][1:0][SIGFIG-1:0]         sample_R14S,
   output logic        [SAMPLES-1:0]                          validSamp_R14H
);

   typedef enum logic {ST_WAIT, ST_TEST} state_e;

   localparam logic [SIGFIG-1:0] ONE = SIGFIG'(1);

   state_e                                          state_q;
   logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]   tri_q;
   logic        [COLORS-1:0][SIGFIG-1:0]            color_q;
   logic signed [SIGFIG-1:0]                        ll_x_q, ur_x_q, ur_y_q;
   logic signed [SIGFIG-1:0]                        step_q, x_q, y_q;

   logic signed [SIGFIG-1:0]                        in_ll_x, in_ll_y, in_ur_x, in_ur_y;
   logic signed [SIGFIG-1:0]                        step_d, row_x_d, next_y_d, lane_x;
   logic                                            box_ok;

   assign in_ll_x = $signed(box_R13S[0][0]);
   assign in_ll_y = $signed(box_R13S[0][1]);
   assign in_ur_x = $signed(box_R13S[1][0]);
   assign in_ur_y = $signed(box_R13S[1][1]);
   assign box_ok  = (in_ll_x <= in_ur_x) && (in_ll_y <= in_ur_y);

   // Non-one-hot spacing codes fall back to one sample per pixel.
   always_comb begin
      case (subSample_R13U)
         4'b1000: step_d = ONE << RADIX;
         4'b0100: step_d = ONE << (RADIX - 1);
         4'b0010: step_d = ONE << (RADIX - 2);
         4'b0001: step_d = ONE << (RADIX - 3);
         default: step_d = ONE << RADIX;
      endcase
   end

   // NOTE: lane_x is a blocking running sum inside always_comb; it is assigned
   // before any read, so no latch is inferred and each lane sees the prior value.
   always_comb begin
      lane_x = x_q;
      for (int k = 0; k < SAMPLES; k++) begin
         sample_R14S[k][0] = lane_x;
         sample_R14S[k][1] = y_q;
         validSamp_R14H[k] = (state_q == ST_TEST) && (lane_x <= ur_x_q);
         lane_x            = lane_x + step_q;
      end
      row_x_d = lane_x;
   end

   assign next_y_d   = y_q + step_q;
   assign halt_R13H  = (state_q == ST_TEST);
   assign tri_R14S   = tri_q;
   assign color_R14U = color_q;

   // NOTE: every register, including the latched triangle data, is cleared by
   // reset so all R14 outputs read zero while rst is low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_WAIT;
         tri_q   <= '0;
         color_q <= '0;
         ll_x_q  <= '0;
         ur_x_q  <= '0;
         ur_y_q  <= '0;
         step_q  <= '0;
         x_q     <= '0;
         y_q     <= '0;
      end else begin
         case (state_q)
            ST_WAIT: begin
               if (validTri_R13H && box_ok) begin
                  tri_q   <= tri_R13S;
                  color_q <= color_R13U;
                  ll_x_q  <= in_ll_x;
                  ur_x_q  <= in_ur_x;
                  ur_y_q  <= in_ur_y;
                  step_q  <= step_d;
                  x_q     <= in_ll_x;
                  y_q     <= in_ll_y;
                  state_q <= ST_TEST;
               end
            end
            ST_TEST: begin
               if (row_x_d <= ur_x_q) begin
                  x_q <= row_x_d;
               end else if (next_y_d > ur_y_q) begin
                  state_q <= ST_WAIT;
               end else begin
                  x_q <= ll_x_q;
                  y_q <= next_y_d;
               end
            end
            default: state_q <= ST_WAIT;
         endcase
      end
   end

endmodule

// File: tb/tb_multi_sample_iterator.sv
// Directed bench: stimulus pushes expected sample groups into a scoreboard,
// a negedge monitor pops and compares whenever any lane is valid.
module tb_multi_sample_iterator;

   localparam int SIG  = 24;
   localparam int SAMP = 2;

   logic                          clk;
   logic                          rst;
   logic signed [2:0][2:0][SIG-1:0] tri_R13S;
   logic        [2:0][SIG-1:0]      color_R13U;
   logic signed [1:0][1:0][SIG-1:0] box_R13S;
   logic        [3:0]             subSample_R13U;
   logic                          validTri_R13H;
   logic                          halt_R13H;
   logic signed [2:0][2:0][SIG-1:0] tri_R14S;
   logic        [2:0][SIG-1:0]      color_R14U;
   logic signed [SAMP-1:0][1:0][SIG-1:0] sample_R14S;
   logic        [SAMP-1:0]        validSamp_R14H;

   multi_sample_iterator dut (
      .clk            (clk),
      .rst            (rst),
      .tri_R13S       (tri_R13S),
      .color_R13U     (color_R13U),
      .box_R13S       (box_R13S),
      .subSample_R13U (subSample_R13U),
      .validTri_R13H  (validTri_R13H),
      .halt_R13H      (halt_R13H),
      .tri_R14S       (tri_R14S),
      .color_R14U     (color_R14U),
      .sample_R14S    (sample_R14S),
      .validSamp_R14H (validSamp_R14H)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [SAMP-1:0][1:0][SIG-1:0] samp;
      logic [SAMP-1:0]               vld;
      int                            tag;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [2:0][2:0][SIG-1:0] mk_tri(input int tag);
      logic [2:0][2:0][SIG-1:0] t;
      for (int v = 0; v < 3; v++)
         for (int a = 0; a < 3; a++)
            t[v][a] = (v == 1) ? SIG'(-(tag * 100 + v * 10 + a)) : SIG'(tag * 100 + v * 10 + a);
      return t;
   endfunction

   function automatic logic [2:0][SIG-1:0] mk_color(input int tag);
      logic [2:0][SIG-1:0] c;
      for (int i = 0; i < 3; i++) c[i] = SIG'(tag * 1000 + i);
      return c;
   endfunction

   task automatic push_grp(input int tag, input int x0, input int y0, input logic v0,
                           input int x1, input int y1, input logic v1);
      exp_t e;
      e.samp[0][0] = SIG'(x0);
      e.samp[0][1] = SIG'(y0);
      e.samp[1][0] = SIG'(x1);
      e.samp[1][1] = SIG'(y1);
      e.vld        = {v1, v0};
      e.tag        = tag;
      sb_q.push_back(e);
   endtask

   task automatic set_inputs(input int tag, input int llx, input int lly,
                             input int urx, input int ury, input logic [3:0] sub);
      tri_R13S       = mk_tri(tag);
      color_R13U     = mk_color(tag);
      box_R13S[0][0] = SIG'(llx);
      box_R13S[0][1] = SIG'(lly);
      box_R13S[1][0] = SIG'(urx);
      box_R13S[1][1] = SIG'(ury);
      subSample_R13U = sub;
   endtask

   // Called just after a negedge; returns one negedge later with validTri low.
   task automatic apply(input int tag, input int llx, input int lly,
                        input int urx, input int ury, input logic [3:0] sub);
      set_inputs(tag, llx, lly, urx, ury, sub);
      validTri_R13H = 1'b1;
      @(negedge clk);
      validTri_R13H = 1'b0;
   endtask

   task automatic run_tri(input int tag, input int llx, input int lly,
                          input int urx, input int ury, input logic [3:0] sub, input int n);
      apply(tag, llx, lly, urx, ury, sub);
      for (int i = 0; i < n; i++) begin
         check($sformatf("halt_test_t%0d_c%0d", tag, i), halt_R13H, 1'b1);
         @(negedge clk);
      end
      check($sformatf("halt_fall_t%0d", tag), halt_R13H, 1'b0);
   endtask

   always @(negedge clk) begin
      if (validSamp_R14H != '0) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_unexpected: got valid=%b sample=%h expected no output",
                     validSamp_R14H, sample_R14S);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check($sformatf("sample_t%0d", e.tag), sample_R14S, e.samp);
            check($sformatf("valid_t%0d", e.tag), validSamp_R14H, e.vld);
            check($sformatf("tri_t%0d", e.tag), tri_R14S, mk_tri(e.tag));
            check($sformatf("color_t%0d", e.tag), color_R14U, mk_color(e.tag));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst            = 1'b0;
      validTri_R13H  = 1'b0;
      set_inputs(0, 0, 0, 0, 0, 4'b0000);

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("rst_halt", halt_R13H, 1'b0);
      check("rst_valid", validSamp_R14H, '0);
      check("rst_sample", sample_R14S, '0);
      check("rst_tri", tri_R14S, '0);
      check("rst_color", color_R14U, '0);
      rst = 1'b1;

      // 2x2 box at full step: two TEST cycles
      push_grp(1, 0, 0, 1'b1, 1024, 0, 1'b1);
      push_grp(1, 0, 1024, 1'b1, 1024, 1024, 1'b1);
      run_tri(1, 0, 0, 1024, 1024, 4'b1000, 2);

      // Single row, second group has lane1 past ur_x
      push_grp(2, 0, 0, 1'b1, 1024, 0, 1'b1);
      push_grp(2, 2048, 0, 1'b1, 3072, 0, 1'b0);
      run_tri(2, 0, 0, 2048, 0, 4'b1000, 2);

      // Degenerate point box, quarter step
      push_grp(3, 5120, 3072, 1'b1, 5376, 3072, 1'b0);
      run_tri(3, 5120, 3072, 5120, 3072, 4'b0010, 1);

      // Inverted box is dropped; next triangle accepted on the following edge
      apply(4, 2048, 0, 1024, 0, 4'b1000);
      check("drop_halt", halt_R13H, 1'b0);
      check("drop_valid", validSamp_R14H, '0);
      push_grp(5, 0, 0, 1'b1, 1024, 0, 1'b0);
      run_tri(5, 0, 0, 0, 0, 4'b1000, 1);

      // Reset during the 3rd TEST cycle of a 4x4-pixel box
      push_grp(6, 0, 0, 1'b1, 1024, 0, 1'b1);
      push_grp(6, 2048, 0, 1'b1, 3072, 0, 1'b1);
      push_grp(6, 0, 1024, 1'b1, 1024, 1024, 1'b1);
      apply(6, 0, 0, 3072, 3072, 4'b1000);
      @(negedge clk);
      @(negedge clk);
      #1 rst = 1'b0;
      #1;
      check("abort_valid", validSamp_R14H, '0);
      check("abort_halt", halt_R13H, 1'b0);
      @(negedge clk);
      check("abort_sample", sample_R14S, '0);
      check("abort_tri", tri_R14S, '0);
      rst = 1'b1;
      push_grp(7, 1024, 2048, 1'b1, 1536, 2048, 1'b0);
      run_tri(7, 1024, 2048, 1024, 2048, 4'b0100, 1);

      // Back-to-back with validTri held high; second is ignored while halted
      push_grp(8, 0, 0, 1'b1, 1024, 0, 1'b1);
      push_grp(9, 0, 0, 1'b1, 1024, 0, 1'b0);
      push_grp(9, 0, 1024, 1'b1, 1024, 1024, 1'b0);
      set_inputs(8, 0, 0, 1024, 0, 4'b1000);
      validTri_R13H = 1'b1;
      @(negedge clk);
      check("b2b_halt_a", halt_R13H, 1'b1);
      set_inputs(9, 0, 0, 0, 1024, 4'b1000);
      @(negedge clk);
      check("b2b_halt_gap", halt_R13H, 1'b0);
      @(negedge clk);
      validTri_R13H = 1'b0;
      check("b2b_halt_b1", halt_R13H, 1'b1);
      @(negedge clk);
      check("b2b_halt_b2", halt_R13H, 1'b1);
      @(negedge clk);
      check("b2b_halt_end", halt_R13H, 1'b0);

      repeat (2) @(negedge clk);
      check("sb_drain", sb_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/multi_sample_iterator.md
MULTI_SAMPLE_ITERATOR -- requirements
Module: multi_sample_iterator

Interface
REQ-001 SHALL have parameter SIGFIG, default 24, bits in position and color.
REQ-002 SHALL have parameter RADIX, default 10, fraction bits in position.
REQ-003 SHALL have parameter VERTS, default 3, vertices per triangle.
REQ-004 SHALL have parameter AXIS, default 3, axes per vertex (x,y,z).
REQ-005 SHALL have parameter COLORS, default 3, color channels.
REQ-006 SHALL have parameter SAMPLES, default 2, sample lanes emitted per cycle.
REQ-007 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-008 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-009 SHALL have port tri_R13S  input  signed [SIGFIG] x VERTS x AXIS  incoming triangle.
REQ-010 SHALL have port color_R13U  input  [SIGFIG] x COLORS  triangle color.
REQ-011 SHALL have port box_R13S  input  signed [SIGFIG] x 2 x 2  bounding box; [0] = lower-left, [1] = upper-right; [.][0] = x, [.][1] = y.
REQ-012 SHALL have port subSample_R13U  input  4  one-hot sample spacing.
REQ-013 SHALL have port validTri_R13H  input  1  triangle present.
REQ-014 SHALL have port halt_R13H  output  1  stall to upstream; high = input not accepted.
REQ-015 SHALL have port tri_R14S  output  signed [SIGFIG] x VERTS x AXIS  latched triangle.
REQ-016 SHALL have port color_R14U  output  [SIGFIG] x COLORS  latched color.
REQ-017 SHALL have port sample_R14S  output  signed [SIGFIG] x SAMPLES x 2  sample (x,y) per lane.
REQ-018 SHALL have port validSamp_R14H  output  1 x SAMPLES  per-lane sample valid.

Function
REQ-019 SHALL implement a two-state FSM: WAIT (idle) and TEST (iterating).
REQ-020 SHALL drive halt_R13H = 1 exactly when the state is TEST.
REQ-021 In WAIT, at a clock edge with validTri_R13H=1, SHALL latch tri, color, box and step, set cursor (x,y) = box lower-left, and enter TEST.
REQ-022 SHALL compute step from subSample_R13U: 1000 -> 1<<RADIX; 0100 -> 1<<(RADIX-1); 0010 -> 1<<(RADIX-2); 0001 -> 1<<(RADIX-3); any non-one-hot value -> 1<<RADIX.
REQ-023 SHALL drop a triangle whose box has ll_x>ur_x or ll_y>ur_y: FSM stays in WAIT, no valid samples.
REQ-024 In TEST, lane k SHALL output sample (x + k*step, y).
REQ-025 Lane k SHALL be valid when x + k*step <= ur_x.
REQ-026 In WAIT, all validSamp lanes SHALL be 0.
REQ-027 After each TEST cycle, when x + SAMPLES*step <= ur_x, SHALL advance to x += SAMPLES*step.
REQ-028 Otherwise SHALL set x = ll_x and y += step.
REQ-029 If that new y > ur_y, SHALL return to WAIT instead of advancing.
REQ-030 SHALL perform all cursor arithmetic at SIGFIG bits signed; the box is within screen range, so no overflow handling.
REQ-031 SHALL derive all R14 outputs from registers only; no combinational path from R13 inputs to R14 outputs.
REQ-032 Latency: a triangle accepted at edge E SHALL present its first sample group in the cycle after E.
REQ-033 A TEST pass SHALL last rows x ceil(cols/SAMPLES) cycles, where rows = (ur_y-ll_y)/step+1 and cols = (ur_x-ll_x)/step+1.
REQ-034 On the last TEST cycle, halt SHALL remain 1; halt SHALL fall in the next cycle, and a new triangle SHALL be accepted at the end of that cycle at the earliest.
REQ-035 Inputs presented while halt=1 SHALL be ignored, and the latched triangle SHALL not change.
REQ-036 SHALL treat a box not aligned to step as follows: start at ll, and use the <= ur comparisons above unchanged.
REQ-037 SHALL hold tri_R14S and color_R14U constant for the whole TEST pass.

Reset
REQ-038 While rst=0, asynchronously: FSM = WAIT, halt_R13H=0, validSamp_R14H all 0, and sample_R14S, tri_R14S, color_R14U and all internal registers 0.
REQ-039 Reset asserted mid-TEST SHALL abort the pass immediately, with no further valid samples.
REQ-040 After rst rises, the first acceptance SHALL occur no earlier than the first rising edge.

Verification
REQ-041 Bench SHALL cover: RADIX=10, SAMPLES=2, box (0,0)-(1024,1024), subSample 1000 -> two TEST cycles: {(0,0),(1024,0)} both valid, then {(0,1024),(1024,1024)} both valid; halt falls the following cycle.
REQ-042 Bench SHALL cover: box (0,0)-(2048,0), step 1024 -> cycle 1 lanes x=0,1024 valid; cycle 2 lane0 x=2048 valid, lane1 x=3072 invalid; then WAIT.
REQ-043 Bench SHALL cover: degenerate box ll=ur=(5120,3072), subSample 0010 -> one cycle, lane0 (5120,3072) valid, lane1 (5376,3072) invalid.
REQ-044 Bench SHALL cover: inverted box ll_x=2048, ur_x=1024 -> halt stays 0, no valid samples, next triangle accepted on the following edge.
REQ-045 Bench SHALL cover: rst=0 pulsed during the 3rd TEST cycle of a 4x4-pixel box -> validSamp and halt go 0 without a clock edge; after release, a new triangle is accepted normally.
REQ-046 Bench SHALL cover: validTri held high for back-to-back triangles -> second triangle latched only on the first WAIT edge after the first pass; its tri_R14S appears with its first sample group; zero lost or duplicated samples.
